// File: rtl/ic_rd_tracker_pkg.sv
// ic_rd_tracker_pkg: shared interconnect widths and the tracker table entry type
package ic_rd_tracker_pkg;
  localparam int MSTR_BITS  = 2;
  localparam int ID_BITS    = 4;
  localparam int DEPTH      = 4;
  localparam int DEPTH_BITS = 2;
  // age counts the valid entries younger than this one, so the oldest has the largest age
  typedef struct packed {
    logic                  vld;
    logic [MSTR_BITS-1:0]  mstr;
    logic [ID_BITS-1:0]    id;
    logic [DEPTH_BITS-1:0] age;
  } entry_t;
endpackage

// File: rtl/ic_rd_tracker_lowfree.sv
// ic_rd_tracker_lowfree: first-zero priority encoder; vld_i -> lowest free index idx_o, none_o when all set
module ic_rd_tracker_lowfree
  import ic_rd_tracker_pkg::*;
(
  input  logic [DEPTH-1:0]      vld_i,
  output logic [DEPTH_BITS-1:0] idx_o,
  output logic                  none_o
);
  always_comb begin
    idx_o = '0;
    none_o = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!vld_i[i]) begin
        idx_o = DEPTH_BITS'(i);
        none_o = 1'b0;
      end
  end
endmodule

// File: rtl/ic_rd_tracker.sv
// ic_rd_tracker: per-slave outstanding-read table; cmd_* allocates {master,id}, r_* resolves beats to r_mstr/r_ok,
// full/count report occupancy, err_orphan pulses on unmatched beats, err_ovf is sticky on allocation while full
module ic_rd_tracker
  import ic_rd_tracker_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic                  cmd_ready,
  input  logic [MSTR_BITS-1:0]  cmd_mstr,
  input  logic [ID_BITS-1:0]    cmd_id,
  output logic                  full,
  output logic [DEPTH_BITS:0]   count,
  input  logic                  r_valid,
  input  logic                  r_ready,
  input  logic                  r_last,
  input  logic [ID_BITS-1:0]    r_id,
  output logic [MSTR_BITS-1:0]  r_mstr,
  output logic                  r_ok,
  output logic                  err_orphan,
  output logic                  err_ovf
);
  entry_t [DEPTH-1:0]    tbl_q, tbl_d;
  logic [DEPTH-1:0]      vld;
  logic [DEPTH_BITS-1:0] free_idx, sel_idx;
  logic                  free_none, alloc_req, alloc, dealloc;
  logic                  err_orphan_q, err_ovf_q;

  ic_rd_tracker_lowfree u_lowfree (
    .vld_i  (vld),
    .idx_o  (free_idx),
    .none_o (free_none)
  );

  always_comb begin
    vld = '0;
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = tbl_q[i].vld;
      count = count + (DEPTH_BITS+1)'(tbl_q[i].vld);
    end
  end

  assign full      = &vld;
  assign alloc_req = cmd_valid & cmd_ready;
  assign alloc     = alloc_req & ~free_none;

  // ages of valid entries are distinct, so the oldest match is unique
  always_comb begin
    r_ok = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (tbl_q[i].vld && tbl_q[i].id == r_id && (!r_ok || tbl_q[i].age > tbl_q[sel_idx].age)) begin
        r_ok = 1'b1;
        sel_idx = DEPTH_BITS'(i);
      end
  end

  assign r_mstr  = r_ok ? tbl_q[sel_idx].mstr : '0;
  assign dealloc = r_valid & r_ready & r_last & r_ok;

  // the freed slot is cleared after the age pass and the new slot is a free one, so neither keeps a stale age
  always_comb begin
    tbl_d = tbl_q;
    for (int i = 0; i < DEPTH; i++)
      if (tbl_q[i].vld)
        tbl_d[i].age = tbl_q[i].age + DEPTH_BITS'(alloc)
                     - DEPTH_BITS'(dealloc && tbl_q[i].age > tbl_q[sel_idx].age);
    if (dealloc) tbl_d[sel_idx] = '0;
    if (alloc) tbl_d[free_idx] = '{vld: 1'b1, mstr: cmd_mstr, id: cmd_id, age: '0};
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tbl_q <= '0;
      err_orphan_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      tbl_q <= tbl_d;
      err_orphan_q <= r_valid & ~r_ok;
      err_ovf_q <= err_ovf_q | (alloc_req & full);
    end

  assign err_orphan = err_orphan_q;
  assign err_ovf    = err_ovf_q;
endmodule

// File: tb/tb_ic_rd_tracker.sv
// tb_ic_rd_tracker: directed stimulus against an issue-order queue model of the read tracker
module tb_ic_rd_tracker;
  import ic_rd_tracker_pkg::*;

  logic                 clk, reset, cmd_valid, cmd_ready, r_valid, r_ready, r_last;
  logic [MSTR_BITS-1:0] cmd_mstr, r_mstr;
  logic [ID_BITS-1:0]   cmd_id, r_id;
  logic [DEPTH_BITS:0]  count;
  logic                 full, r_ok, err_orphan, err_ovf;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [MSTR_BITS-1:0] mstr;
    logic [ID_BITS-1:0]   id;
  } ent_t;

  ent_t q[$];
  bit   m_ovf = 0;
  bit   m_orph = 0;

  ic_rd_tracker dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mstr(cmd_mstr), .cmd_id(cmd_id), .full(full), .count(count),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .r_id(r_id),
    .r_mstr(r_mstr), .r_ok(r_ok), .err_orphan(err_orphan), .err_ovf(err_ovf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // the oldest outstanding read with this id sits first in the issue-order queue
  function automatic int find(input logic [ID_BITS-1:0] id);
    for (int i = 0; i < q.size(); i++)
      if (q[i].id == id) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_orph = 0;
    end else begin
      int k;
      bit fl;
      k = find(r_id);
      fl = (q.size() == DEPTH);
      m_orph = r_valid && k < 0;
      if (cmd_valid && cmd_ready && fl) m_ovf = 1;
      if (r_valid && r_ready && r_last && k >= 0) q.delete(k);
      if (cmd_valid && cmd_ready && !fl) q.push_back('{cmd_mstr, cmd_id});
    end
  end

  always @(negedge clk)
    if (!reset) begin
      int k;
      k = find(r_id);
      chk("m_full", 32'(full), 32'(q.size() == DEPTH));
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_r_ok", 32'(r_ok), 32'(k >= 0));
      chk("m_r_mstr", 32'(r_mstr), k >= 0 ? 32'(q[k].mstr) : 32'd0);
      chk("m_err_orphan", 32'(err_orphan), 32'(m_orph));
      chk("m_err_ovf", 32'(err_ovf), 32'(m_ovf));
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; cmd_valid = 0; cmd_ready = 1; cmd_mstr = 0; cmd_id = 0;
    r_valid = 0; r_ready = 0; r_last = 0; r_id = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1 chk("init_full", 32'(full), 0); chk("init_count", 32'(count), 0);
    chk("init_ovf", 32'(err_ovf), 0); chk("init_r_ok", 32'(r_ok), 0);
    // single read; a beat in the AR cycle must not match
    cyc();
    cmd_valid = 1; cmd_mstr = 2; cmd_id = 5; r_valid = 1; r_id = 5; r_ready = 0;
    #1 chk("t2_ar_cycle_r_ok", 32'(r_ok), 0);
    cyc();
    cmd_valid = 0; r_ready = 1;
    for (int b = 0; b < 4; b++) begin
      r_last = (b == 3);
      #1 chk("t2_r_mstr", 32'(r_mstr), 2); chk("t2_r_ok", 32'(r_ok), 1); chk("t2_count", 32'(count), 1);
      if (b == 0) chk("t2_orphan_pulse", 32'(err_orphan), 1);
      cyc();
    end
    r_valid = 0; r_last = 0;
    #1 chk("t2_count_after", 32'(count), 0);
    // same id from two masters returns in issue order
    cmd_valid = 1; cmd_mstr = 1; cmd_id = 3; cyc();
    cmd_mstr = 2; cyc();
    cmd_valid = 0; r_valid = 1; r_id = 3;
    for (int b = 0; b < 4; b++) begin
      r_last = (b % 2 == 1);
      #1 chk("t3_order", 32'(r_mstr), b < 2 ? 1 : 2);
      cyc();
    end
    r_valid = 0; r_last = 0;
    #1 chk("t3_count_after", 32'(count), 0);
    // fill, then overflow attempt
    cmd_valid = 1;
    for (int k = 0; k < 4; k++) begin
      cmd_mstr = 2'(k); cmd_id = 4'(k + 1); cyc();
    end
    cmd_valid = 0;
    #1 chk("t4_full", 32'(full), 1); chk("t4_count", 32'(count), 4);
    cmd_valid = 1; cmd_mstr = 3; cmd_id = 7; cyc();
    cmd_valid = 0;
    #1 chk("t4_ovf", 32'(err_ovf), 1); chk("t4_count_kept", 32'(count), 4);
    r_valid = 1; r_ready = 0; r_id = 7;
    #1 chk("t4_no_entry7", 32'(r_ok), 0);
    r_id = 4;
    #1 chk("t4_id4_mstr", 32'(r_mstr), 3);
    // drain one, start a burst, then reset mid-burst with 3 entries valid
    r_ready = 1; r_id = 1; r_last = 1; cyc();
    r_id = 2; r_last = 0; cyc();
    #1 chk("t1_count3", 32'(count), 3); chk("t1_mid_mstr", 32'(r_mstr), 1);
    reset = 1;
    #1 chk("t1_full", 32'(full), 0); chk("t1_count", 32'(count), 0);
    chk("t1_r_ok", 32'(r_ok), 0); chk("t1_ovf", 32'(err_ovf), 0); chk("t1_r_mstr", 32'(r_mstr), 0);
    cyc();
    reset = 0;
    #1 chk("t1_after_r_ok", 32'(r_ok), 0);
    r_valid = 0; cyc();
    // simultaneous last beat and AR on a full table
    cmd_valid = 1;
    for (int k = 0; k < 4; k++) begin
      cmd_mstr = 2'(k); cmd_id = 4'(k + 1); cyc();
    end
    cmd_mstr = 2; cmd_id = 9; r_valid = 1; r_ready = 1; r_last = 1; r_id = 2;
    #1 chk("t5_sel_mstr", 32'(r_mstr), 1); chk("t5_full", 32'(full), 1);
    cyc();
    cmd_valid = 0; r_valid = 0;
    #1 chk("t5_ovf", 32'(err_ovf), 1); chk("t5_count", 32'(count), 3); chk("t5_not_full", 32'(full), 0);
    cmd_valid = 1; cmd_mstr = 3; cmd_id = 1; cyc();
    cmd_valid = 0;
    #1 chk("t5_refill_count", 32'(count), 4); chk("t5_refill_full", 32'(full), 1);
    r_valid = 1; r_ready = 1; r_last = 1; r_id = 1;
    #1 chk("t5_older_first", 32'(r_mstr), 0);
    cyc();
    #1 chk("t5_new_youngest", 32'(r_mstr), 3); chk("t5_count3", 32'(count), 3);
    cyc();
    r_valid = 0;
    #1 chk("t5_count2", 32'(count), 2);
    // orphan beat
    r_valid = 1; r_id = 9;
    #1 chk("t6_r_ok", 32'(r_ok), 0); chk("t6_r_mstr", 32'(r_mstr), 0);
    cyc();
    r_valid = 0; r_last = 0;
    #1 chk("t6_orphan", 32'(err_orphan), 1); chk("t6_count", 32'(count), 2);
    cyc();
    #1 chk("t6_orphan_clear", 32'(err_orphan), 0);
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
